// File: rtl/inst_rom_loader.sv
// inst_rom_loader
// Instruction ROM for a small CPU. The ROM contents are loaded at run time
// from a byte stream. Each group of four bytes, sent most-significant byte
// first, forms one 32-bit word. Once the load ends, the CPU fetches words
// combinationally by byte address.
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous reset, active low
//   ce_i        CPU fetch enable
//   addr_i      CPU fetch byte address
//   inst_o      fetched instruction (zero when the fetch is not served)
//   busy_o      high while not in RUN
//   err_o       one-cycle pulse after a misaligned or out-of-range fetch
//   ld_start_i  begin or restart a program load
//   ld_end_i    finish the load and enter RUN
//   ld_valid_i  load byte valid
//   ld_data_i   load byte
//   ld_ready_o  loader can accept a byte this cycle
//   words_o     complete words written in the current load
module inst_rom_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_i,
  input  logic [31:0]   addr_i,
  output logic [31:0]   inst_o,
  output logic          busy_o,
  output logic          err_o,
  input  logic          ld_start_i,
  input  logic          ld_end_i,
  input  logic          ld_valid_i,
  input  logic [7:0]    ld_data_i,
  output logic          ld_ready_o,
  output logic [AW:0]   words_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneWord   = (AW+1)'(1);

  state_t      state_q;
  logic [AW:0] wordCnt_q;
  logic [1:0]  byteCnt_q;
  logic [31:0] asmWord_q;
  logic [31:0] asmWord_d;
  logic        err_q;
  logic        byteAccept;
  logic        wordWrite;
  logic        badAddr;
  logic        fetchOk;
  logic        fetchBad;

  logic [31:0] mem [DEPTH];

  // Load handshake. The word count doubles as the write pointer. Its top bit
  // is set only when the memory is full, and at that point ready drops, so
  // the pointer can never wrap back onto word 0.
  // Start and end requests take priority over a byte arriving on the same
  // edge, so that byte is dropped together with any partial word.
  assign ld_ready_o = (state_q == LOAD) && (wordCnt_q < FullCount);
  assign byteAccept = ld_valid_i && ld_ready_o && !ld_start_i && !ld_end_i;
  assign asmWord_d  = {asmWord_q[23:0], ld_data_i};
  assign wordWrite  = rst && byteAccept && (byteCnt_q == 2'd3);

  // Fetch side. Only aligned, in-range addresses in RUN are served.
  assign badAddr  = (addr_i[31:AW+2] != '0) || (addr_i[1:0] != 2'b00);
  assign fetchOk  = (state_q == RUN) && ce_i && !badAddr;
  assign fetchBad = (state_q == RUN) && ce_i && badAddr;
  assign inst_o   = fetchOk ? mem[addr_i[AW+1:2]] : 32'h0;

  assign busy_o  = (state_q != RUN);
  assign err_o   = err_q;
  assign words_o = wordCnt_q;

  // Controller and byte assembler. Reset clears only the bookkeeping state.
  // The memory keeps every word that was completed before the reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      wordCnt_q <= '0;
      byteCnt_q <= '0;
      asmWord_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= fetchBad;
      if (ld_start_i) begin
        state_q   <= LOAD;
        wordCnt_q <= '0;
        byteCnt_q <= '0;
        asmWord_q <= '0;
      end else if (ld_end_i && (state_q != RUN)) begin
        state_q   <= RUN;
        byteCnt_q <= '0;
        asmWord_q <= '0;
      end else if (byteAccept) begin
        asmWord_q <= asmWord_d;
        if (byteCnt_q == 2'd3) begin
          wordCnt_q <= wordCnt_q + OneWord;
          byteCnt_q <= '0;
        end else begin
          byteCnt_q <= byteCnt_q + 2'd1;
        end
      end
    end
  end

  // Word storage. There is no reset and no clear, so the contents survive
  // a reset and a load restart.
  always_ff @(posedge clk) begin
    if (wordWrite) begin
      mem[wordCnt_q[AW-1:0]] <= asmWord_d;
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader
// Directed bench for inst_rom_loader. It drives two instances from the same
// stimulus: one with the default 1024-word depth and one with only 4 words,
// so the memory-full behaviour can be reached quickly.
module tb_inst_rom_loader;

  logic        clk;
  logic        rst;
  logic        ceIn;
  logic [31:0] addrIn;
  logic        ldStart;
  logic        ldEnd;
  logic        ldValid;
  logic [7:0]  ldData;

  logic [31:0] instBig,  instSmall;
  logic        busyBig,  busySmall;
  logic        errBig,   errSmall;
  logic        readyBig, readySmall;
  logic [10:0] wordsBig;
  logic [2:0]  wordsSmall;

  int checkCount = 0;
  int errorCount = 0;

  inst_rom_loader dutBig (
    .clk(clk), .rst(rst), .ce_i(ceIn), .addr_i(addrIn), .inst_o(instBig),
    .busy_o(busyBig), .err_o(errBig), .ld_start_i(ldStart), .ld_end_i(ldEnd),
    .ld_valid_i(ldValid), .ld_data_i(ldData), .ld_ready_o(readyBig),
    .words_o(wordsBig)
  );

  inst_rom_loader #(.DEPTH(4), .AW(2)) dutSmall (
    .clk(clk), .rst(rst), .ce_i(ceIn), .addr_i(addrIn), .inst_o(instSmall),
    .busy_o(busySmall), .err_o(errSmall), .ld_start_i(ldStart), .ld_end_i(ldEnd),
    .ld_valid_i(ldValid), .ld_data_i(ldData), .ld_ready_o(readySmall),
    .words_o(wordsSmall)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value with its expected value and counts the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advances to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the load controls for a single edge, then releases them.
  task automatic applyStimulus(input logic start, input logic stop,
                               input logic valid, input logic [7:0] data);
    ldStart = start;
    ldEnd   = stop;
    ldValid = valid;
    ldData  = data;
    tick();
    ldStart = 1'b0;
    ldEnd   = 1'b0;
    ldValid = 1'b0;
  endtask

  // Sends one word as four bytes, most-significant byte first.
  task automatic sendWord(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, w[i*8 +: 8]);
  endtask

  // Presents a fetch address and lets the combinational output settle.
  task automatic setFetch(input logic ce, input logic [31:0] a);
    ceIn   = ce;
    addrIn = a;
    #1;
  endtask

  initial begin
    rst = 1'b0; ceIn = 1'b1; addrIn = 32'h0;
    ldStart = 1'b0; ldEnd = 1'b0; ldValid = 1'b0; ldData = 8'h0;

    // Reset behaviour.
    tick(); tick();
    checkOutput("rst busy", busyBig, 1);
    checkOutput("rst ready", readyBig, 0);
    checkOutput("rst inst", instBig, 0);
    rst = 1'b1;
    tick();
    checkOutput("post-rst busy", busyBig, 1);
    checkOutput("post-rst ready", readyBig, 0);
    checkOutput("post-rst inst", instBig, 0);
    checkOutput("post-rst words", wordsBig, 0);
    checkOutput("post-rst err", errBig, 0);
    checkOutput("post-rst small busy", busySmall, 1);

    // Load a single word, then fetch it in the same cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("load ready", readyBig, 1);
    sendWord(32'h34010010);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("one word count", wordsBig, 1);
    checkOutput("run busy", busyBig, 0);
    setFetch(1'b1, 32'h0);
    checkOutput("one word inst", instBig, 32'h34010010);
    checkOutput("one word inst small", instSmall, 32'h34010010);

    // Fill four words so that mem[3] holds a known value.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    sendWord(32'h11223344); sendWord(32'h55667788);
    sendWord(32'h99AABBCC); sendWord(32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("four words", wordsBig, 4);
    setFetch(1'b1, 32'h4);
    checkOutput("fetch word1", instBig, 32'h55667788);
    setFetch(1'b1, 32'hC);
    checkOutput("fetch word3", instBig, 32'hDEADBEEF);

    // Reload three words plus two bytes. The partial word must be dropped.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    sendWord(32'hA0A1A2A3); sendWord(32'hB0B1B2B3); sendWord(32'hC0C1C2C3);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hEE);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("partial words", wordsBig, 3);
    checkOutput("partial words small", wordsSmall, 3);
    setFetch(1'b1, 32'h0);
    checkOutput("reload word0", instBig, 32'hA0A1A2A3);
    setFetch(1'b1, 32'h8);
    checkOutput("reload word2 small", instSmall, 32'hC0C1C2C3);
    setFetch(1'b1, 32'hC);
    checkOutput("word3 kept", instBig, 32'hDEADBEEF);
    checkOutput("word3 kept small", instSmall, 32'hDEADBEEF);

    // Fetch errors: an out-of-range address, then a misaligned one.
    setFetch(1'b1, 32'h00001000);
    checkOutput("range inst", instBig, 0);
    tick();
    checkOutput("range err", errBig, 1);
    checkOutput("range err small", errSmall, 1);
    setFetch(1'b1, 32'h2);
    checkOutput("align inst", instBig, 0);
    tick();
    checkOutput("align err", errBig, 1);
    setFetch(1'b1, 32'h0);
    tick();
    checkOutput("err one pulse", errBig, 0);
    setFetch(1'b0, 32'h00001000);
    tick();
    checkOutput("ce0 range err", errBig, 0);
    setFetch(1'b0, 32'h2);
    checkOutput("ce0 inst", instBig, 0);
    tick();
    checkOutput("ce0 align err", errBig, 0);
    setFetch(1'b1, 32'h10);
    tick();
    checkOutput("edge err big", errBig, 0);
    checkOutput("edge err small", errSmall, 1);
    setFetch(1'b1, 32'hFFC);
    tick();
    checkOutput("top word err", errBig, 0);
    setFetch(1'b0, 32'h0);

    // Bytes offered in RUN must be ignored.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h55);
    checkOutput("run ignores bytes", wordsBig, 3);

    // Stream 20 bytes. The small instance fills after 16 bytes.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    sendWord(32'h01020304); sendWord(32'h05060708);
    sendWord(32'h090A0B0C); sendWord(32'h0D0E0F10);
    checkOutput("full ready small", readySmall, 0);
    checkOutput("full words small", wordsSmall, 4);
    checkOutput("not full ready big", readyBig, 1);
    sendWord(32'h11121314);
    checkOutput("overflow words small", wordsSmall, 4);
    checkOutput("five words big", wordsBig, 5);
    checkOutput("full busy small", busySmall, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    setFetch(1'b1, 32'h0);
    checkOutput("no wrap word0", instSmall, 32'h01020304);
    setFetch(1'b1, 32'hC);
    checkOutput("full word3 small", instSmall, 32'h0D0E0F10);
    setFetch(1'b1, 32'h10);
    checkOutput("word4 big", instBig, 32'h11121314);
    checkOutput("word4 small nop", instSmall, 0);
    setFetch(1'b0, 32'h0);

    // Start and end together in RUN: start wins.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("start wins busy", busyBig, 1);
    checkOutput("start wins words", wordsBig, 0);
    checkOutput("start wins ready", readyBig, 1);

    // Reset mid-load keeps completed words and drops the partial word.
    sendWord(32'hCAFEF00D);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h77);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h88);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("midload rst words", wordsBig, 0);
    checkOutput("midload rst ready", readyBig, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h99);
    checkOutput("idle ignores bytes", wordsBig, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("idle to run", busyBig, 0);
    setFetch(1'b1, 32'h0);
    checkOutput("kept after rst", instBig, 32'hCAFEF00D);
    checkOutput("kept after rst small", instSmall, 32'hCAFEF00D);
    setFetch(1'b1, 32'h4);
    checkOutput("word1 after rst", instBig, 32'h05060708);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
